sha3_digest_streamer: RTL
=========================

SHA3_DIGEST_STREAMER -- requirements
Module: sha3_digest_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, output beat width in bits; legal values 16 and 32 only.
REQ-002 SHALL have port ACLK  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Din  input  [4:0][4:0][63:0]  final Keccak state; lane i (0..24) = Din[i/5][i%5].
REQ-005 SHALL have port Din_valid  input  1  Din, Mode_i and Dest_i are valid this cycle.
REQ-006 SHALL have port Din_ready  output  1  block can accept a digest.
REQ-007 SHALL have port Mode_i  input  2  digest mode: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
REQ-008 SHALL have port Dest_i  input  8  routing tag copied to TDEST for the whole frame.
REQ-009 SHALL have port TDATA  output  DATA_WIDTH  digest beat.
REQ-010 SHALL have ports TVALID, TLAST  output  1 each  AXI-Stream valid and end of frame.
REQ-011 SHALL have port TKEEP  output  DATA_WIDTH/8  byte qualifier, constant all-ones.
REQ-012 SHALL have port TDEST  output  8  captured Dest_i.
REQ-013 SHALL have port TREADY  input  1  downstream accept.
REQ-014 SHALL have port Frame_cnt  output  16  count of completed digest frames.

Function
REQ-015 SHALL implement FSM IDLE -> SEND -> IDLE; Din_ready = 1 only in IDLE.
REQ-016 In IDLE with Din_valid=1, SHALL capture lanes 0..7 (512 bits), Mode_i and Dest_i, then enter SEND next cycle.
REQ-017 TVALID SHALL assert the cycle after capture: one-cycle latency; no combinational path Din_valid->TVALID.
REQ-018 Beat count SHALL be digest bits/DATA_WIDTH: 224->14/7, 256->16/8, 384->24/12, 512->32/16 (for DATA_WIDTH 16/32).
REQ-019 Beat k SHALL carry digest bytes k*DATA_WIDTH/8 upward, little-endian; byte n = lane n/8, bits [8*(n%8)+7 : 8*(n%8)].
REQ-020 A beat SHALL transfer only when TVALID&TREADY; otherwise TDATA, TLAST and TDEST hold stable and the beat counter holds.
REQ-021 TLAST SHALL be 1 exactly on the final beat of the captured mode.
REQ-022 On final-beat transfer: return to IDLE, Frame_cnt += 1 (wraps 16'hFFFF -> 0), TVALID = 0 next cycle.
REQ-023 Din_valid in SEND SHALL be ignored (Din_ready=0); upstream holds it until IDLE.
REQ-024 Mode_i/Dest_i changes in SEND SHALL not affect the frame in flight.
REQ-025 Back-to-back: Din_valid held high SHALL capture in the IDLE cycle after a final beat; one idle TVALID=0 cycle between frames is required.
REQ-026 TREADY held low indefinitely SHALL stall with no data loss or counter change.

Reset
REQ-027 ARESETn low SHALL immediately force IDLE, TVALID=0, TLAST=0, TDATA=0, TDEST=0, Frame_cnt=0, beat counter=0, Din_ready=0 while asserted.
REQ-028 Reset mid-frame SHALL discard the frame; first cycle after deassertion Din_ready=1.

Structure
REQ-029 Mode encoding enum, digest-byte constants (28/32/48/64) and lane-index mapping SHALL live in shared package sha3_pkg.
REQ-030 SHALL be single module, no sub-modules; capture register is 512 bits, beat selected by counter-indexed mux.

Verification
REQ-031 SHA3-256 empty-message state (digest a7ffc6f8...), TREADY=1, DATA_WIDTH=16 -> 16 beats, beat0 TDATA=16'hffa7, TLAST only on beat 15, Frame_cnt=1.
REQ-032 Mode 0 with lanes 0..3 = 64'h0706050403020100, 64'h0F0E..08, 64'h1716..10, 64'h1F1E..18 -> 14 beats 16'h0100..16'h1b1a, TLAST on beat 13.
REQ-033 Mode 3, TREADY toggling 1,0,0,1 -> exactly 32 transfers, TDATA stable while stalled, TDEST = Dest_i (8'h5A) throughout.
REQ-034 Din_valid held high for two digests (modes 1 then 2) -> 16-beat frame, one idle cycle, 24-beat frame; second captured only after first TLAST.
REQ-035 ARESETn pulsed low at beat 5 of a mode-3 frame -> TVALID=0 asynchronously, Frame_cnt=0, next frame starts from beat 0.
REQ-036 Preload Frame_cnt to 16'hFFFF (force) and send one frame -> Frame_cnt=16'h0000.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared SHA3 digest definitions: mode encoding, digest sizes and the
// mapping from linear Keccak lane index to the [row][column] state layout.
package sha3_pkg;

  typedef enum logic [1:0] {
    MODE_SHA3_224 = 2'd0,
    MODE_SHA3_256 = 2'd1,
    MODE_SHA3_384 = 2'd2,
    MODE_SHA3_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } stream_state_e;

  localparam int unsigned DIGEST_BYTES_224 = 32'd28;
  localparam int unsigned DIGEST_BYTES_256 = 32'd32;
  localparam int unsigned DIGEST_BYTES_384 = 32'd48;
  localparam int unsigned DIGEST_BYTES_512 = 32'd64;
  localparam int unsigned CAPTURE_LANES    = 32'd8;
  localparam int unsigned CAPTURE_BITS     = 32'd512;

  function automatic int unsigned digest_bytes(input sha3_mode_e mode);
    case (mode)
      MODE_SHA3_224: return DIGEST_BYTES_224;
      MODE_SHA3_256: return DIGEST_BYTES_256;
      MODE_SHA3_384: return DIGEST_BYTES_384;
      MODE_SHA3_512: return DIGEST_BYTES_512;
      default:       return DIGEST_BYTES_512;
    endcase
  endfunction

  // Lane i of the Keccak state sits at Din[i/5][i%5].
  function automatic logic [2:0] lane_row(input int unsigned lane);
    return 3'(lane / 32'd5);
  endfunction

  function automatic logic [2:0] lane_col(input int unsigned lane);
    return 3'(lane % 32'd5);
  endfunction

endpackage

// File: rtl/sha3_digest_streamer.sv
// Captures the first 512 bits of a final Keccak state and streams the
// selected SHA3 digest out as an AXI-Stream frame, little-endian by byte.
module sha3_digest_streamer
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [4:0][4:0][63:0]       Din,
  input  logic                        Din_valid,
  output logic                        Din_ready,
  input  logic [1:0]                  Mode_i,
  input  logic [7:0]                  Dest_i,
  output logic [DATA_WIDTH-1:0]       TDATA,
  output logic                        TVALID,
  output logic                        TLAST,
  output logic [DATA_WIDTH/8-1:0]     TKEEP,
  output logic [7:0]                  TDEST,
  input  logic                        TREADY,
  output logic [15:0]                 Frame_cnt
);

  localparam int NUM_BEATS = CAPTURE_BITS / DATA_WIDTH;
  localparam int BW        = $clog2(NUM_BEATS);

  function automatic logic [BW-1:0] last_beat(input sha3_mode_e mode);
    return BW'(digest_bytes(mode) * 32'd8 / DATA_WIDTH - 32'd1);
  endfunction

  stream_state_e                            state_q, state_d;
  logic [NUM_BEATS-1:0][DATA_WIDTH-1:0]     cap_q, cap_d;
  logic [CAPTURE_LANES-1:0][63:0]           lanes_s;
  sha3_mode_e                               mode_q, mode_d;
  logic [7:0]                               dest_q, dest_d;
  logic [BW-1:0]                            beat_q, beat_d;
  logic [DATA_WIDTH-1:0]                    tdata_q, tdata_d;
  logic                                     tlast_q, tlast_d;
  logic [15:0]                              frame_cnt_q, frame_cnt_d;
  logic                                     unused_lanes_s;

  for (genvar i = 0; i < CAPTURE_LANES; i++) begin : g_lane
    assign lanes_s[i] = Din[lane_row(i)][lane_col(i)];
  end

  // Lanes 8..24 never reach the digest.
  assign unused_lanes_s = ^Din;

  // Next-state logic: capture in IDLE, advance one beat per accepted transfer in SEND.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    mode_d      = mode_q;
    dest_d      = dest_q;
    beat_d      = beat_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Din_valid) begin
          state_d = ST_SEND;
          cap_d   = lanes_s;
          mode_d  = sha3_mode_e'(Mode_i);
          dest_d  = Dest_i;
          beat_d  = '0;
          tdata_d = lanes_s[0][DATA_WIDTH-1:0];
          tlast_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (TREADY) begin
          if (tlast_q) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            tlast_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            beat_d  = beat_q + BW'(1);
            tdata_d = cap_q[beat_d];
            tlast_d = (beat_d == last_beat(mode_q));
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      cap_q       <= '0;
      mode_q      <= MODE_SHA3_224;
      dest_q      <= 8'd0;
      beat_q      <= '0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      mode_q      <= mode_d;
      dest_q      <= dest_d;
      beat_q      <= beat_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign Din_ready = ARESETn & (state_q == ST_IDLE);
  assign TVALID    = (state_q == ST_SEND);
  assign TDATA     = tdata_q;
  assign TLAST     = tlast_q;
  assign TDEST     = dest_q;
  assign TKEEP     = {(DATA_WIDTH/8){1'b1}};
  assign Frame_cnt = frame_cnt_q;

endmodule
